// File: rtl/multimode_ff_bank_pkg.sv
// Shared definitions for the configurable flip-flop bank.
// Each channel uses a 2-bit mode code that selects its flip-flop type.
package ff_bank_pkg;
   localparam logic [1:0] MODE_D  = 2'b00;
   localparam logic [1:0] MODE_T  = 2'b01;
   localparam logic [1:0] MODE_SR = 2'b10;
   localparam logic [1:0] MODE_JK = 2'b11;
endpackage

// File: rtl/multimode_ff_bank_ff_cell.sv
// Combinational next-state logic for a single channel of the bank.
// It also raises a flag when an SR channel sees S=R=1.
module ff_cell
   import ff_bank_pkg::*;
(
   input  logic [1:0] mode,
   input  logic       a,
   input  logic       b,
   input  logic       q,
   output logic       q_nxt,
   output logic       ill
);

   always_comb begin
      q_nxt = q;
      ill   = 1'b0;
      unique case (mode)
         MODE_D:  q_nxt = a;
         MODE_T:  q_nxt = a ? ~q : q;
         MODE_SR: begin
            // S=R=1 holds the current state and reports the illegal input
            unique case ({a, b})
               2'b10:   q_nxt = 1'b1;
               2'b01:   q_nxt = 1'b0;
               2'b11:   ill   = 1'b1;
               default: q_nxt = q;
            endcase
         end
         default: begin
            unique case ({a, b})
               2'b10:   q_nxt = 1'b1;
               2'b01:   q_nxt = 1'b0;
               2'b11:   q_nxt = ~q;
               default: q_nxt = q;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multimode_ff_bank.sv
// WIDTH-channel register bank; each bit acts per cycle as a D, T, SR or JK flip-flop.
// Adds a sticky illegal-SR error per channel and a saturating change counter.
module multimode_ff_bank
   import ff_bank_pkg::*;
#(
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   parameter int                CNT_W     = 8
) (
   input  logic                 c,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [2*WIDTH-1:0]   mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 err_clr,
   output logic [WIDTH-1:0]     q,
   output logic [WIDTH-1:0]     q_n,
   output logic [WIDTH-1:0]     err,
   output logic [CNT_W-1:0]     chg_cnt
);

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] ill;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ff_cell u_cell (
         .mode  (mode[2*i+1:2*i]),
         .a     (a[i]),
         .b     (b[i]),
         .q     (q_q[i]),
         .q_nxt (q_nxt[i]),
         .ill   (ill[i])
      );
   end

   always_comb begin
      q_d   = q_q;
      err_d = err_q;
      cnt_d = cnt_q;
      if (err_clr) begin
         err_d = '0;
      end
      // A new illegal SR in the clearing cycle is OR-ed in after the clear, so it survives
      if (en) begin
         q_d   = q_nxt;
         err_d = err_d | ill;
         if ((|(q_nxt ^ q_q)) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         q_q   <= RESET_VAL;
         err_q <= '0;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign q       = q_q;
   assign q_n     = ~q_q;
   assign err     = err_q;
   assign chg_cnt = cnt_q;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed bench for multimode_ff_bank: one 8-bit-counter instance with RESET_VAL=A5
// and one 2-bit-counter instance with RESET_VAL=00 share the same stimulus.
module tb_multimode_ff_bank;

   logic        c;
   logic        rst_n;
   logic        en;
   logic [15:0] mode;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        err_clr;

   logic [7:0]  q_a, qn_a, err_a, cnt_a;
   logic [7:0]  q_b, qn_b, err_b;
   logic [1:0]  cnt_b;

   int checks;
   int errors;

   multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(8)) u_dut_a (
      .c(c), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
      .q(q_a), .q_n(qn_a), .err(err_a), .chg_cnt(cnt_a)
   );

   multimode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(2)) u_dut_b (
      .c(c), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
      .q(q_b), .q_n(qn_b), .err(err_b), .chg_cnt(cnt_b)
   );

   initial begin
      c = 1'b0;
      forever #5 c = ~c;
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge c);
      #1;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b1;
      en      = 1'b0;
      mode    = 16'h0000;
      a       = 8'h00;
      b       = 8'h00;
      err_clr = 1'b0;

      // Asynchronous reset, observed before any clock edge
      #3 rst_n = 1'b0;
      #1;
      chk("rst_q_a",   16'(q_a),   16'h00A5);
      chk("rst_qn_a",  16'(qn_a),  16'h005A);
      chk("rst_err_a", 16'(err_a), 16'h0000);
      chk("rst_cnt_a", 16'(cnt_a), 16'h0000);
      chk("rst_q_b",   16'(q_b),   16'h0000);
      chk("rst_qn_b",  16'(qn_b),  16'h00FF);
      step();
      rst_n = 1'b1;
      step();
      chk("hold_en0_q_a", 16'(q_a), 16'h00A5);

      // Preload A with zeros via D mode
      en = 1'b1; mode = 16'h0000; a = 8'h00;
      step();
      chk("pre_q_a",   16'(q_a),   16'h0000);
      chk("pre_cnt_a", 16'(cnt_a), 16'h0001);
      chk("pre_cnt_b", 16'(cnt_b), 16'h0000);

      // Mixed modes ch3..0 = JK,SR,T,D
      mode = 16'h00E4; a = 8'h0F; b = 8'h0C;
      step();
      chk("mix_q_a",   16'(q_a),   16'h000B);
      chk("mix_qn_a",  16'(qn_a),  16'h00F4);
      chk("mix_err_a", 16'(err_a), 16'h0004);
      chk("mix_cnt_a", 16'(cnt_a), 16'h0002);
      chk("mix_q_b",   16'(q_b),   16'h000B);
      chk("mix_cnt_b", 16'(cnt_b), 16'h0001);

      // Clear q, then JK toggle for four edges
      mode = 16'h0000; a = 8'h00; b = 8'h00;
      step();
      chk("clr_q_a", 16'(q_a), 16'h0000);
      mode = 16'hFFFF; a = 8'hFF; b = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("jk_q_a", 16'(q_a), (i % 2 == 0) ? 16'h00FF : 16'h0000);
      end
      chk("jk_cnt_a", 16'(cnt_a), 16'h0007);

      // Disabled: q, err and counter hold regardless of inputs
      en = 1'b0; mode = 16'h0000; a = 8'h5A;
      for (int i = 0; i < 3; i++) step();
      chk("dis_q_a",   16'(q_a),   16'h0000);
      chk("dis_cnt_a", 16'(cnt_a), 16'h0007);
      chk("dis_err_a", 16'(err_a), 16'h0004);

      // err_clr alone clears; q does not change
      en = 1'b1; err_clr = 1'b1; mode = 16'h0000; a = 8'h00;
      step();
      chk("eclr_err_a", 16'(err_a), 16'h0000);
      chk("eclr_cnt_a", 16'(cnt_a), 16'h0007);

      // err_clr together with SR 11 on ch5: new error wins
      mode = 16'h0800; a = 8'h20; b = 8'h20;
      step();
      chk("eprio_err_a", 16'(err_a), 16'h0020);
      chk("eprio_q_a",   16'(q_a),   16'h0000);
      err_clr = 1'b0;

      // Illegal SR with en=0 must not set err
      en = 1'b0; mode = 16'h0002; a = 8'h01; b = 8'h01;
      step();
      chk("ill_en0_err_a", 16'(err_a), 16'h0020);

      // SR set/reset/hold
      en = 1'b1; mode = 16'hAAAA; a = 8'h0F; b = 8'hF0;
      step();
      chk("sr_set_q_a", 16'(q_a), 16'h000F);
      a = 8'hF0; b = 8'h0F;
      step();
      chk("sr_swap_q_a", 16'(q_a), 16'h00F0);
      a = 8'h00; b = 8'h00;
      step();
      chk("sr_hold_q_a",   16'(q_a),   16'h00F0);
      chk("sr_hold_cnt_a", 16'(cnt_a), 16'h0009);
      chk("sr_err_a",      16'(err_a), 16'h0020);

      // Reset, then saturation with all-T toggling
      rst_n = 1'b0;
      #1;
      chk("rst2_cnt_b", 16'(cnt_b), 16'h0000);
      chk("rst2_err_a", 16'(err_a), 16'h0000);
      step();
      rst_n = 1'b1;
      mode = 16'h5555; a = 8'hFF; b = 8'h00; en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("sat_cnt_b", 16'(cnt_b), (i < 3) ? 16'(i + 1) : 16'h0003);
         chk("sat_q_a",   16'(q_a),   (i % 2 == 0) ? 16'h005A : 16'h00A5);
      end
      chk("sat_cnt_a", 16'(cnt_a), 16'h0006);

      // Reset mid-operation while toggling, release between edges
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_q_a",   16'(q_a),   16'h00A5);
      chk("mrst_qn_a",  16'(qn_a),  16'h005A);
      chk("mrst_cnt_a", 16'(cnt_a), 16'h0000);
      chk("mrst_q_b",   16'(q_b),   16'h0000);
      chk("mrst_cnt_b", 16'(cnt_b), 16'h0000);
      step();
      #1 rst_n = 1'b1;
      #1;
      chk("rel_q_a", 16'(q_a), 16'h00A5);
      step();
      chk("rel_upd_q_a",   16'(q_a),   16'h005A);
      chk("rel_upd_cnt_a", 16'(cnt_a), 16'h0001);
      chk("rel_upd_q_b",   16'(q_b),   16'h00FF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
